// File: rtl/hline_motion_ctrl.sv
// Bounces the moving horizontal line between Y=18 and Y=630 by pulsing the
// coordinate counter's UP/DW/LD inputs once every speed+1 video frames.
module hline_motion_ctrl #(
    parameter int unsigned SPEED_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic               start,
    input  logic               halt,
    input  logic               at_top,
    input  logic               at_bottom,
    input  logic [SPEED_W-1:0] speed,
    output logic               UP,
    output logic               DW,
    output logic               LD,
    output logic               dir,
    output logic               moving
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e             r_state, w_state_d;
    logic [SPEED_W-1:0] r_fcnt, w_fcnt_d;
    logic               r_dir, w_dir_d;
    logic               r_up, w_up_d;
    logic               r_dw, w_dw_d;
    logic               r_ld, w_ld_d;
    logic               r_moving;

    always_comb begin
        w_state_d = r_state;
        w_fcnt_d  = r_fcnt;
        w_dir_d   = r_dir;
        w_up_d    = 1'b0;
        w_dw_d    = 1'b0;
        w_ld_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && !halt) begin
                    w_state_d = StLoad;
                    w_ld_d    = 1'b1;
                end
            end
            StLoad: begin
                w_fcnt_d  = '0;
                w_state_d = StRun;
            end
            StRun: begin
                if (halt) begin
                    w_state_d = StIdle;
                    w_fcnt_d  = '0;
                end else if (frame) begin
                    if (r_fcnt < speed) begin
                        w_fcnt_d = r_fcnt + SPEED_W'(1);
                    end else begin
                        w_fcnt_d = '0;
                        // Flags reflect the pre-step position; both set is illegal.
                        if (!(at_top && at_bottom)) begin
                            if (r_dir) begin
                                if (at_top) begin
                                    w_dir_d = 1'b0;
                                    w_dw_d  = 1'b1;
                                end else begin
                                    w_up_d  = 1'b1;
                                end
                            end else begin
                                if (at_bottom) begin
                                    w_dir_d = 1'b1;
                                    w_up_d  = 1'b1;
                                end else begin
                                    w_dw_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_fcnt   <= '0;
            r_dir    <= 1'b1;
            r_up     <= 1'b0;
            r_dw     <= 1'b0;
            r_ld     <= 1'b0;
            r_moving <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_fcnt   <= w_fcnt_d;
            r_dir    <= w_dir_d;
            r_up     <= w_up_d;
            r_dw     <= w_dw_d;
            r_ld     <= w_ld_d;
            r_moving <= (w_state_d == StRun);
        end
    end

    assign UP     = r_up;
    assign DW     = r_dw;
    assign LD     = r_ld;
    assign dir    = r_dir;
    assign moving = r_moving;

endmodule

// File: tb/tb_hline_motion_ctrl.sv
// Directed bench for hline_motion_ctrl; expected {UP,DW,LD,dir,moving} words
// go through a scoreboard queue and are checked one cycle after each drive.
module tb_hline_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame, start, halt, at_top, at_bottom;
    logic [1:0] speed;
    logic       UP, DW, LD, dir, moving;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [4:0] sb[$];

    hline_motion_ctrl #(.SPEED_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .frame     (frame),
        .start     (start),
        .halt      (halt),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .speed     (speed),
        .UP        (UP),
        .DW        (DW),
        .LD        (LD),
        .dir       (dir),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    // exp bit order: {UP, DW, LD, dir, moving}
    task automatic cyc(input string tag, input logic rst, input logic fr, input logic st,
                       input logic hl, input logic [4:0] exp);
        logic [4:0] got;
        logic [4:0] want;
        reset = rst;
        frame = fr;
        start = st;
        halt  = hl;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        got  = {UP, DW, LD, dir, moving};
        want = sb.pop_front();
        vec_cnt++;
        assert (got === want) else begin
            err_cnt++;
            $error("FAIL %s: got UP,DW,LD,dir,moving=%b expected %b", tag, got, want);
        end
    endtask

    initial begin
        reset = 1'b1; frame = 1'b0; start = 1'b0; halt = 1'b0;
        at_top = 1'b0; at_bottom = 1'b0; speed = 2'd0;
        #2;

        cyc("reset_state",   1, 0, 0, 0, 5'b00010);
        cyc("idle",          0, 0, 0, 0, 5'b00010);
        cyc("idle_frame",    0, 1, 0, 0, 5'b00010);
        cyc("start_halt",    0, 0, 1, 1, 5'b00010);
        cyc("start_ld",      0, 0, 1, 0, 5'b00110);
        cyc("load_halt_ign", 0, 0, 0, 1, 5'b00011);

        // speed 0: every frame steps
        cyc("sp0_up1",       0, 1, 0, 0, 5'b10011);
        cyc("sp0_gap",       0, 0, 0, 0, 5'b00011);
        cyc("sp0_up2",       0, 1, 0, 0, 5'b10011);
        cyc("sp0_up3",       0, 1, 0, 0, 5'b10011);
        cyc("start_in_run",  0, 0, 1, 0, 5'b00011);

        // divider: steps on frames 3, 6, 9
        speed = 2'd2;
        for (int i = 1; i <= 9; i++) begin
            cyc($sformatf("div_f%0d", i), 0, 1, 0, 0, (i % 3 == 0) ? 5'b10011 : 5'b00011);
            cyc("div_gap", 0, 0, 0, 0, 5'b00011);
        end

        // fcnt reaches 2, then speed drops to 0
        cyc("dec_f1",        0, 1, 0, 0, 5'b00011);
        cyc("dec_f2",        0, 1, 0, 0, 5'b00011);
        speed = 2'd0;
        cyc("dec_step",      0, 1, 0, 0, 5'b10011);

        // bounce at top, travel down, bounce at bottom
        at_top = 1'b1;
        cyc("bounce_top",    0, 1, 0, 0, 5'b01001);
        cyc("after_top",     0, 0, 0, 0, 5'b00001);
        at_top = 1'b0;
        cyc("down_step",     0, 1, 0, 0, 5'b01001);
        at_bottom = 1'b1;
        cyc("bounce_bot",    0, 1, 0, 0, 5'b10011);
        at_top = 1'b1;
        cyc("both_flags",    0, 1, 0, 0, 5'b00011);
        at_top = 1'b0; at_bottom = 1'b0;

        cyc("halt_frame",    0, 1, 0, 1, 5'b00010);
        cyc("idle_after",    0, 1, 0, 0, 5'b00010);

        // restart at speed 2: halt must have cleared fcnt
        speed = 2'd2;
        cyc("restart_ld",    0, 0, 1, 0, 5'b00110);
        cyc("restart_run",   0, 0, 0, 0, 5'b00011);
        cyc("rs_f1",         0, 1, 0, 0, 5'b00011);
        cyc("rs_f2",         0, 1, 0, 0, 5'b00011);
        cyc("rs_f3",         0, 1, 0, 0, 5'b10011);

        // reach RUN with dir=0 and fcnt=1, then reset
        speed = 2'd0; at_top = 1'b1;
        cyc("pre_rst_top",   0, 1, 0, 0, 5'b01001);
        at_top = 1'b0; speed = 2'd2;
        cyc("pre_rst_cnt",   0, 1, 0, 0, 5'b00001);
        cyc("mid_reset",     1, 0, 0, 0, 5'b00010);
        cyc("post_rst_f1",   0, 1, 0, 0, 5'b00010);
        cyc("post_rst_f2",   0, 1, 0, 0, 5'b00010);
        cyc("post_rst_f3",   0, 1, 0, 0, 5'b00010);

        // reset landing on a live UP pulse
        speed = 2'd0;
        cyc("rst2_ld",       0, 0, 1, 0, 5'b00110);
        cyc("rst2_run",      0, 0, 0, 0, 5'b00011);
        cyc("rst2_up",       0, 1, 0, 0, 5'b10011);
        cyc("rst2_clear",    1, 1, 0, 0, 5'b00010);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
